sreg_access_ctrl: RTL and testbench

Initiator/sequencer for the eight-entry 16-bit scalar register file: turns single-beat valid/ready requests (read, full write, low-byte write, high-byte write) into correctly timed Addr/DataIn/RD/WR/WR_l/WR_h strobes. Read data is captured from the register file's DataOut and returned on a valid/ready response channel. Sits between the instruction decode/execute stage and the scalar register file. One request is in flight at a time.

---
 rtl/sreg_access_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sreg_access_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_access_ctrl.sv
// Request sequencer for the 8x16 scalar register file: strobe timing, read capture, response handshake.
// Optional RdCount/WrCount statistics are built when SREG_ACC_STATS_EN is defined.
module sreg_access_ctrl #(
   parameter int STROBE_CYC = 1,
   parameter int READ_LAT   = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [1:0]  ReqOp,
   input  logic [2:0]  ReqAddr,
   input  logic [15:0] ReqData,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [15:0] RspData,
   output logic [2:0]  RspAddr,
   output logic [2:0]  Addr,
   output logic [15:0] DataIn,
   output logic        RD,
   output logic        WR,
   output logic        WR_l,
   output logic        WR_h,
   input  logic [15:0] DataOut,
`ifdef SREG_ACC_STATS_EN
   input  logic        StatClr,
   output logic [15:0] RdCount,
   output logic [15:0] WrCount,
`endif
   output logic        Busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STROBE  = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_HOLD    = 3'd5,
      S_RESP    = 3'd6
   } state_t;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_WRL = 2'b10;
   localparam logic [1:0] OP_WRH = 2'b11;

   // Counter reload values are one less than the dwell time: the state exits when the count reaches zero.
   localparam logic [2:0] STROBE_LOAD = 3'(STROBE_CYC - 1);
   localparam logic [2:0] READ_LOAD   = 3'(READ_LAT - 1);
   localparam logic [2:0] HOLD_LOAD   = (HOLD_CYC > 0) ? 3'(HOLD_CYC - 1) : 3'd0;
   localparam logic       HOLD_EN     = (HOLD_CYC > 0) ? 1'b1 : 1'b0;

   state_t      state_r;
   state_t      next_state_s;
   logic [2:0]  cnt_r;
   logic [2:0]  next_cnt_s;
   logic [1:0]  op_r;
   logic        accept_s;
   logic        next_strobe_s;

   // Next-state and dwell-counter logic.
   always_comb begin
      next_state_s = state_r;
      next_cnt_s   = cnt_r;
      accept_s     = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (ReqValid) begin
               accept_s     = 1'b1;
               next_state_s = S_SETUP;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_SETUP: begin
            next_state_s = S_STROBE;
            next_cnt_s   = STROBE_LOAD;
         end
         S_STROBE: begin
            if (cnt_r != 3'd0) begin
               next_cnt_s = cnt_r - 3'd1;
            end else if (op_r == OP_RD) begin
               next_state_s = S_WAIT;
               next_cnt_s   = READ_LOAD;
            end else if (HOLD_EN) begin
               next_state_s = S_HOLD;
               next_cnt_s   = HOLD_LOAD;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_r != 3'd0) begin
               next_cnt_s = cnt_r - 3'd1;
            end else begin
               next_state_s = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            next_state_s = S_RESP;
         end
         S_HOLD: begin
            if (cnt_r != 3'd0) begin
               next_cnt_s = cnt_r - 3'd1;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_RESP: begin
            if (RspReady) begin
               next_state_s = S_IDLE;
            end else begin
               next_state_s = S_RESP;
            end
         end
         default: begin
            next_state_s = S_IDLE;
            next_cnt_s   = 3'd0;
         end
      endcase
   end

   assign next_strobe_s = (next_state_s == S_STROBE);

   // State, counter and captured request registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r <= S_IDLE;
         cnt_r   <= 3'd0;
         op_r    <= OP_RD;
         Addr    <= 3'd0;
         DataIn  <= 16'd0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= next_cnt_s;
         if (accept_s) begin
            op_r   <= ReqOp;
            Addr   <= ReqAddr;
            DataIn <= ReqData;
         end
      end
   end

   // Outputs are registered from the next state so they line up exactly with state_r.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ReqReady <= 1'b1;
         Busy     <= 1'b0;
         RspValid <= 1'b0;
         RspData  <= 16'd0;
         RspAddr  <= 3'd0;
         RD       <= 1'b0;
         WR       <= 1'b0;
         WR_l     <= 1'b0;
         WR_h     <= 1'b0;
      end else begin
         ReqReady <= (next_state_s == S_IDLE);
         Busy     <= (next_state_s != S_IDLE);
         RspValid <= (next_state_s == S_RESP);
         RD       <= next_strobe_s && (op_r == OP_RD);
         WR       <= next_strobe_s && (op_r == OP_WR);
         WR_l     <= next_strobe_s && (op_r == OP_WRL);
         WR_h     <= next_strobe_s && (op_r == OP_WRH);
         if (state_r == S_CAPTURE) begin
            RspData <= DataOut;
            RspAddr <= Addr;
         end
      end
   end

`ifdef SREG_ACC_STATS_EN
   // Access statistics; a clear in the same cycle as an increment leaves the counter at zero.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RdCount <= 16'd0;
         WrCount <= 16'd0;
      end else if (StatClr) begin
         RdCount <= 16'd0;
         WrCount <= 16'd0;
      end else begin
         if (state_r == S_CAPTURE) begin
            RdCount <= RdCount + 16'd1;
         end else begin
            RdCount <= RdCount;
         end
         if ((state_r == S_SETUP) && (op_r != OP_RD)) begin
            WrCount <= WrCount + 16'd1;
         end else begin
            WrCount <= WrCount;
         end
      end
   end
`else
   // This build carries no statistics ports or counters.
`endif

endmodule

// File: tb/tb_sreg_access_ctrl.sv
// Self-checking bench for sreg_access_ctrl: default instance plus a STROBE_CYC=3/READ_LAT=1/HOLD_CYC=0 instance.
`timescale 1ns/1ps
module tb_sreg_access_ctrl;

   localparam int A_S = 1, A_L = 2, A_H = 1;
   localparam int B_S = 3, B_L = 1, B_H = 0;
   localparam int NV  = 14;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Rst_n, ReqValid, RspReady, sel, rf_init;
   logic [1:0]  ReqOp;
   logic [2:0]  ReqAddr;
   logic [15:0] ReqData;

   logic        a_ready, a_rsp_valid, a_rd, a_wr, a_wrl, a_wrh, a_busy;
   logic [15:0] a_rsp_data, a_din, a_dout;
   logic [2:0]  a_rsp_addr, a_addr;
   logic        b_ready, b_rsp_valid, b_rd, b_wr, b_wrl, b_wrh, b_busy;
   logic [15:0] b_rsp_data, b_din, b_dout;
   logic [2:0]  b_rsp_addr, b_addr;
   logic [15:0] rf_a [8];
   logic [15:0] rf_b [8];

`ifdef SREG_ACC_STATS_EN
   logic        StatClr;
   logic [15:0] a_rdcnt, a_wrcnt, b_rdcnt, b_wrcnt;
`endif

   sreg_access_ctrl #(.STROBE_CYC(A_S), .READ_LAT(A_L), .HOLD_CYC(A_H)) dut_a (
      .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid & ~sel), .ReqReady(a_ready),
      .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqData(ReqData),
      .RspValid(a_rsp_valid), .RspReady(RspReady), .RspData(a_rsp_data), .RspAddr(a_rsp_addr),
      .Addr(a_addr), .DataIn(a_din), .RD(a_rd), .WR(a_wr), .WR_l(a_wrl), .WR_h(a_wrh),
      .DataOut(a_dout),
`ifdef SREG_ACC_STATS_EN
      .StatClr(StatClr), .RdCount(a_rdcnt), .WrCount(a_wrcnt),
`endif
      .Busy(a_busy));

   sreg_access_ctrl #(.STROBE_CYC(B_S), .READ_LAT(B_L), .HOLD_CYC(B_H)) dut_b (
      .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid & sel), .ReqReady(b_ready),
      .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqData(ReqData),
      .RspValid(b_rsp_valid), .RspReady(RspReady), .RspData(b_rsp_data), .RspAddr(b_rsp_addr),
      .Addr(b_addr), .DataIn(b_din), .RD(b_rd), .WR(b_wr), .WR_l(b_wrl), .WR_h(b_wrh),
      .DataOut(b_dout),
`ifdef SREG_ACC_STATS_EN
      .StatClr(StatClr), .RdCount(b_rdcnt), .WrCount(b_wrcnt),
`endif
      .Busy(b_busy));

   // Register file models: combinational read, strobed byte-lane writes.
   function automatic logic [15:0] rf_next(input logic [15:0] old, input logic [15:0] din,
                                           input logic wr, input logic wl, input logic wh);
      logic [15:0] v;
      v = old;
      if (wr) v = din;
      if (wl) v[7:0] = din[7:0];
      if (wh) v[15:8] = din[15:8];
      return v;
   endfunction

   assign a_dout = rf_a[a_addr];
   assign b_dout = rf_b[b_addr];

   always @(posedge Clk) begin
      if (rf_init) begin
         for (int i = 0; i < 8; i++) begin
            rf_a[i] <= 16'h1000 + 16'(i);
            rf_b[i] <= 16'h1000 + 16'(i);
         end
      end else begin
         rf_a[a_addr] <= rf_next(rf_a[a_addr], a_din, a_wr, a_wrl, a_wrh);
         rf_b[b_addr] <= rf_next(rf_b[b_addr], b_din, b_wr, b_wrl, b_wrh);
      end
   end

   logic        m_ready, m_busy, m_rsp_valid, m_rd, m_wr, m_wrl, m_wrh;
   logic [15:0] m_rsp_data, m_din;
   logic [2:0]  m_rsp_addr, m_addr;
   assign m_ready     = sel ? b_ready     : a_ready;
   assign m_busy      = sel ? b_busy      : a_busy;
   assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign m_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
   assign m_rsp_addr  = sel ? b_rsp_addr  : a_rsp_addr;
   assign m_addr      = sel ? b_addr      : a_addr;
   assign m_din       = sel ? b_din       : a_din;
   assign m_rd        = sel ? b_rd        : a_rd;
   assign m_wr        = sel ? b_wr        : a_wr;
   assign m_wrl       = sel ? b_wrl       : a_wrl;
   assign m_wrh       = sel ? b_wrh       : a_wrh;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   // Strobe monitor: running strobe-cycle totals and violation counts, checked by the main sequence.
   logic        mon_en = 1'b0, mon_wr = 1'b0;
   logic [2:0]  mon_addr = 3'd0;
   logic [15:0] mon_data = 16'd0;
   int tot_rd = 0, tot_wr = 0, tot_wrl = 0, tot_wrh = 0, v_hot = 0, v_addr = 0, v_din = 0;
   always @(negedge Clk) begin
      if (mon_en) begin
         tot_rd  <= tot_rd  + int'(m_rd);
         tot_wr  <= tot_wr  + int'(m_wr);
         tot_wrl <= tot_wrl + int'(m_wrl);
         tot_wrh <= tot_wrh + int'(m_wrh);
         if ($countones({m_rd, m_wr, m_wrl, m_wrh}) > 1) v_hot <= v_hot + 1;
         if (m_busy && (m_addr !== mon_addr)) v_addr <= v_addr + 1;
         if (m_busy && mon_wr && (m_din !== mon_data)) v_din <= v_din + 1;
      end
   end

   typedef struct { logic [2:0] addr; logic [15:0] data; } rsp_t;
   typedef struct { logic [1:0] op; logic [2:0] addr; logic [15:0] data; logic [15:0] exp; } vec_t;
   rsp_t sb_q[$];
   vec_t vecs[NV];
   int n_cmp = 0, n_fail = 0;
   int s_rd, s_wr, s_wrl, s_wrh, s_hot, s_addr, s_din;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int p_s(); return sel ? B_S : A_S; endfunction
   function automatic int p_lat(); return sel ? (2 + B_S + B_L) : (2 + A_S + A_L); endfunction
   function automatic int p_occ(); return sel ? (1 + B_S + B_H) : (1 + A_S + A_H); endfunction

   task automatic snap();
      s_rd = tot_rd; s_wr = tot_wr; s_wrl = tot_wrl; s_wrh = tot_wrh;
      s_hot = v_hot; s_addr = v_addr; s_din = v_din;
   endtask

   task automatic check_strobes(input int e_rd, input int e_wr, input int e_wrl, input int e_wrh);
      check("rd_cycles",  32'(tot_rd - s_rd),   32'(e_rd));
      check("wr_cycles",  32'(tot_wr - s_wr),   32'(e_wr));
      check("wrl_cycles", 32'(tot_wrl - s_wrl), 32'(e_wrl));
      check("wrh_cycles", 32'(tot_wrh - s_wrh), 32'(e_wrh));
      check("strobe_onehot_viol", 32'(v_hot - s_hot), 32'd0);
      check("addr_stable_viol", 32'(v_addr - s_addr), 32'd0);
      check("din_stable_viol", 32'(v_din - s_din), 32'd0);
   endtask

   task automatic send(input logic [1:0] op, input logic [2:0] addr, input logic [15:0] data,
                       input logic [15:0] exp, output int acc);
      int guard;
      ReqOp = op; ReqAddr = addr; ReqData = data; ReqValid = 1'b1;
      mon_addr = addr; mon_data = data; mon_wr = (op != 2'b00);
      guard = 0;
      while (m_ready !== 1'b1 && guard < 50) begin
         @(negedge Clk);
         guard++;
      end
      check("accept_ready", 32'(m_ready), 32'd1);
      snap();
      if (op == 2'b00) sb_q.push_back(rsp_t'{addr, exp});
      acc = cyc + 1;
      @(negedge Clk);
      ReqValid = 1'b0;
      ReqOp    = 2'($urandom_range(0, 3));
      ReqAddr  = 3'($urandom_range(0, 7));
      ReqData  = 16'($urandom);
   endtask

   task automatic finish_write(input logic [1:0] op, input int acc);
      int guard;
      guard = 0;
      while (m_ready !== 1'b1 && guard < 50) begin
         @(negedge Clk);
         guard++;
      end
      check("wr_occupancy", 32'(cyc - acc), 32'(p_occ()));
      check_strobes(0, (op == 2'b01) ? p_s() : 0, (op == 2'b10) ? p_s() : 0, (op == 2'b11) ? p_s() : 0);
   endtask

   task automatic finish_read(input int acc, input int hold);
      int guard;
      rsp_t r;
      guard = 0;
      while (m_rsp_valid !== 1'b1 && guard < 50) begin
         @(negedge Clk);
         guard++;
      end
      check("rd_latency", 32'(cyc - acc), 32'(p_lat()));
      if (sb_q.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
         r = rsp_t'{3'd0, 16'd0};
      end else begin
         r = sb_q.pop_front();
      end
      check("rsp_data", 32'(m_rsp_data), 32'(r.data));
      check("rsp_addr", 32'(m_rsp_addr), 32'(r.addr));
      for (int i = 0; i < hold; i++) begin
         check("bp_valid", 32'(m_rsp_valid), 32'd1);
         check("bp_data", 32'(m_rsp_data), 32'(r.data));
         check("bp_addr", 32'(m_rsp_addr), 32'(r.addr));
         check("bp_req_ready", 32'(m_ready), 32'd0);
         @(negedge Clk);
      end
      RspReady = 1'b1;
      @(negedge Clk);
      check("rsp_valid_drop", 32'(m_rsp_valid), 32'd0);
      check("idle_after_rsp", 32'(m_ready), 32'd1);
      check_strobes(p_s(), 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      vecs[0]  = '{2'b01, 3'd3, 16'hA5C3, 16'h0000};
      vecs[1]  = '{2'b00, 3'd3, 16'h0000, 16'hA5C3};
      vecs[2]  = '{2'b01, 3'd5, 16'h1234, 16'h0000};
      vecs[3]  = '{2'b10, 3'd5, 16'h00FF, 16'h0000};
      vecs[4]  = '{2'b11, 3'd5, 16'hAB00, 16'h0000};
      vecs[5]  = '{2'b00, 3'd5, 16'hFFFF, 16'hABFF};
      vecs[6]  = '{2'b00, 3'd1, 16'h0000, 16'h1001};
      vecs[7]  = '{2'b01, 3'd0, 16'hFFFF, 16'h0000};
      vecs[8]  = '{2'b10, 3'd0, 16'h0000, 16'h0000};
      vecs[9]  = '{2'b00, 3'd0, 16'h0000, 16'hFF00};
      vecs[10] = '{2'b01, 3'd7, 16'h5A5A, 16'h0000};
      vecs[11] = '{2'b11, 3'd7, 16'h3C00, 16'h0000};
      vecs[12] = '{2'b00, 3'd7, 16'h0000, 16'h3C5A};
      vecs[13] = '{2'b00, 3'd3, 16'h0000, 16'hA5C3};

      Rst_n = 1'b0; ReqValid = 1'b0; ReqOp = 2'b00; ReqAddr = 3'd0; ReqData = 16'd0;
      RspReady = 1'b1; sel = 1'b0; rf_init = 1'b1;
`ifdef SREG_ACC_STATS_EN
      StatClr = 1'b0;
`endif
      repeat (2) @(negedge Clk);
      rf_init = 1'b0;
      ReqValid = 1'b1; ReqOp = 2'b00; ReqAddr = 3'd4; ReqData = 16'hFFFF;
      @(negedge Clk);
      check("rst_req_ready", 32'(a_ready), 32'd1);
      check("rst_strobes", 32'({a_rd, a_wr, a_wrl, a_wrh}), 32'd0);
      check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(a_rsp_data), 32'd0);
      check("rst_rsp_addr", 32'(a_rsp_addr), 32'd0);
      check("rst_addr_din", 32'({a_addr, a_din}), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_b_ready_busy", 32'({b_ready, b_busy}), 32'h2);
      mon_addr = 3'd4; mon_wr = 1'b0; mon_en = 1'b1;
      sb_q.push_back(rsp_t'{3'd4, 16'h1004});
      snap();
      Rst_n = 1'b1;
      acc = cyc + 1;
      @(negedge Clk);
      check("first_edge_busy", 32'(a_busy), 32'd1);
      check("first_edge_addr", 32'(a_addr), 32'd4);
      check("first_edge_ready", 32'(a_ready), 32'd0);
      ReqValid = 1'b0;
      finish_read(acc, 0);

      for (int i = 0; i < NV; i++) begin
         send(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp, acc);
         if (vecs[i].op == 2'b00) finish_read(acc, 0);
         else finish_write(vecs[i].op, acc);
      end

      RspReady = 1'b0;
      send(2'b00, 3'd3, 16'h0000, 16'hA5C3, acc);
      finish_read(acc, 4);

      // Abort a write while WR is high; the register must keep its old value.
      send(2'b01, 3'd2, 16'hDEAD, 16'h0000, acc);
      @(negedge Clk);
      check("wr_before_reset", 32'(a_wr), 32'd1);
      #2 Rst_n = 1'b0;
      #1;
      check("wr_async_drop", 32'(a_wr), 32'd0);
      check("reset_mid_busy", 32'(a_busy), 32'd0);
      check("reset_mid_ready", 32'(a_ready), 32'd1);
      snap();
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (3) @(negedge Clk);
      check_strobes(0, 0, 0, 0);
      send(2'b00, 3'd2, 16'h0000, 16'h1002, acc);
      finish_read(acc, 0);

      sel = 1'b1;
      send(2'b01, 3'd6, 16'h4321, 16'h0000, acc);
      finish_write(2'b01, acc);
      send(2'b00, 3'd6, 16'h0000, 16'h4321, acc);
      finish_read(acc, 0);
      sel = 1'b0;

`ifdef SREG_ACC_STATS_EN
      StatClr = 1'b1;
      @(negedge Clk);
      StatClr = 1'b0;
      check("stat_clr", 32'({a_rdcnt, a_wrcnt}), 32'd0);
      send(2'b01, 3'd1, 16'h0101, 16'h0000, acc); finish_write(2'b01, acc);
      send(2'b10, 3'd1, 16'h0022, 16'h0000, acc); finish_write(2'b10, acc);
      send(2'b11, 3'd1, 16'h3300, 16'h0000, acc); finish_write(2'b11, acc);
      send(2'b00, 3'd1, 16'h0000, 16'h3322, acc); finish_read(acc, 0);
      send(2'b00, 3'd3, 16'h0000, 16'hA5C3, acc); finish_read(acc, 0);
      check("rd_count", 32'(a_rdcnt), 32'd2);
      check("wr_count", 32'(a_wrcnt), 32'd3);
`endif

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
